// File: rtl/sprite_mover.sv
// sprite_mover: moves a BOX_W x BOX_H box around the 160x120 VGA adapter's
// pixel-write port. On a move request the box is erased at its old position
// in bg_colour, a clamped target is computed, and the box is redrawn there in
// fg_colour. After reset the initial box is drawn at (X_INIT, Y_INIT).
//
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   go                         move request, only sampled in IDLE
//   move_left/right/up/down    direction bits, latched with go
//   fg_colour, bg_colour       draw / erase colours
//   x, y, colour, plot         pixel-write port to the VGA adapter
//   busy                       high whenever not IDLE (and during reset)
//   done                       one-cycle pulse when a request or the initial draw completes
//   pos_x, pos_y               current top-left corner of the box
//
// Optional feature: define SPRITE_OUTLINE_EN to draw only the box outline.
// Erase always fills the full box and the sweep timing does not change.
module sprite_mover #(
  parameter int BOX_W    = 4,
  parameter int BOX_H    = 4,
  parameter int SCREEN_W = 160,
  parameter int SCREEN_H = 120,
  parameter int STEP     = 1,
  parameter int X_INIT   = 2,
  parameter int Y_INIT   = 114,
  parameter int XW       = 8,
  parameter int YW       = 7
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          go,
  input  logic          move_left,
  input  logic          move_right,
  input  logic          move_up,
  input  logic          move_down,
  input  logic [2:0]    fg_colour,
  input  logic [2:0]    bg_colour,
  output logic [XW-1:0] x,
  output logic [YW-1:0] y,
  output logic [2:0]    colour,
  output logic          plot,
  output logic          busy,
  output logic          done,
  output logic [XW-1:0] pos_x,
  output logic [YW-1:0] pos_y
);

  typedef enum logic [2:0] {S_IDLE, S_CALC, S_ERASE, S_DRAW, S_DONE} state_t;

  // Box dimensions are limited to 16, so 4-bit sweep counters always suffice.
  localparam int CW = 4;

  localparam logic signed [XW:0] STEP_X = (XW+1)'(STEP);
  localparam logic signed [YW:0] STEP_Y = (YW+1)'(STEP);
  localparam logic signed [XW:0] MAX_X  = (XW+1)'(SCREEN_W - BOX_W);
  localparam logic signed [YW:0] MAX_Y  = (YW+1)'(SCREEN_H - BOX_H);
  localparam logic [XW-1:0]      X0     = XW'(X_INIT);
  localparam logic [YW-1:0]      Y0     = YW'(Y_INIT);
  localparam logic [CW-1:0]      CX_MAX = CW'(BOX_W - 1);
  localparam logic [CW-1:0]      CY_MAX = CW'(BOX_H - 1);

  state_t        state;
  logic [CW-1:0] cx, cy;
  logic [3:0]    dir;          // {left, right, up, down}
  logic [XW-1:0] tgt_x, tx;
  logic [YW-1:0] tgt_y, ty;
  logic signed [XW:0] dx, sum_x;
  logic signed [YW:0] dy, sum_y;
  logic          last_px;
  logic          draw_px;

  // Target position: opposing direction bits cancel, result is clamped to the
  // screen with no wrap-around.
  always_comb begin
    dx = '0;
    if (dir[2] && !dir[3])      dx = STEP_X;
    else if (dir[3] && !dir[2]) dx = -STEP_X;
    dy = '0;
    if (dir[0] && !dir[1])      dy = STEP_Y;
    else if (dir[1] && !dir[0]) dy = -STEP_Y;

    sum_x = $signed({1'b0, pos_x}) + dx;
    sum_y = $signed({1'b0, pos_y}) + dy;

    if (sum_x < 0)          tx = '0;
    else if (sum_x > MAX_X) tx = MAX_X[XW-1:0];
    else                    tx = sum_x[XW-1:0];

    if (sum_y < 0)          ty = '0;
    else if (sum_y > MAX_Y) ty = MAX_Y[YW-1:0];
    else                    ty = sum_y[YW-1:0];
  end

  assign last_px = (cx == CX_MAX) && (cy == CY_MAX);

`ifdef SPRITE_OUTLINE_EN
  assign draw_px = (cx == '0) || (cx == CX_MAX) || (cy == '0) || (cy == CY_MAX);
`else
  assign draw_px = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_DRAW;
      pos_x <= X0;
      pos_y <= Y0;
      tgt_x <= X0;
      tgt_y <= Y0;
      cx    <= '0;
      cy    <= '0;
      dir   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (go) begin
            dir   <= {move_left, move_right, move_up, move_down};
            state <= S_CALC;
          end
        end
        S_CALC: begin
          tgt_x <= tx;
          tgt_y <= ty;
          cx    <= '0;
          cy    <= '0;
          state <= (tx == pos_x && ty == pos_y) ? S_DONE : S_ERASE;
        end
        S_ERASE, S_DRAW: begin
          if (cx == CX_MAX) begin
            cx <= '0;
            cy <= (cy == CY_MAX) ? '0 : cy + 1'b1;
          end else begin
            cx <= cx + 1'b1;
          end
          if (last_px) begin
            if (state == S_ERASE) begin
              // Position only changes once the old box is fully erased.
              pos_x <= tgt_x;
              pos_y <= tgt_y;
              state <= S_DRAW;
            end else begin
              state <= S_DONE;
            end
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Moore decode; reset masks plot/done immediately so a reset during a sweep
  // stops pixel writes even before the state register has been forced.
  assign x      = pos_x + XW'(cx);
  assign y      = pos_y + YW'(cy);
  assign colour = (state == S_ERASE) ? bg_colour : fg_colour;
  assign plot   = !reset && ((state == S_ERASE) || (state == S_DRAW && draw_px));
  assign done   = !reset && (state == S_DONE);
  assign busy   = reset || (state != S_IDLE);

endmodule

// File: tb/tb_sprite_mover.sv
// Self-checking bench for sprite_mover (default parameters). Expected pixels
// are pushed to a scoreboard queue when a request is driven; plotted pixels
// are collected per request and compared in order.
module tb_sprite_mover;

  localparam int BOX_W = 4, BOX_H = 4, SCREEN_W = 160, SCREEN_H = 120;
  localparam int STEP = 1, X_INIT = 2, Y_INIT = 114, XW = 8, YW = 7;
  localparam int MAXC = 80;

  typedef logic [XW+YW+2:0] pix_t;  // {x, y, colour}

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          go = 1'b0;
  logic          move_left = 1'b0, move_right = 1'b0, move_up = 1'b0, move_down = 1'b0;
  logic [2:0]    fg_colour = 3'b110;
  logic [2:0]    bg_colour = 3'b001;
  logic [XW-1:0] x, pos_x;
  logic [YW-1:0] y, pos_y;
  logic [2:0]    colour;
  logic          plot, busy, done;

  int   checks = 0;
  int   errors = 0;
  int   px = X_INIT, py = Y_INIT;  // model position
  pix_t exp_q[$];
  pix_t got_q[$];

  sprite_mover #(
    .BOX_W(BOX_W), .BOX_H(BOX_H), .SCREEN_W(SCREEN_W), .SCREEN_H(SCREEN_H),
    .STEP(STEP), .X_INIT(X_INIT), .Y_INIT(Y_INIT), .XW(XW), .YW(YW)
  ) dut (
    .clk(clk), .reset(reset), .go(go),
    .move_left(move_left), .move_right(move_right), .move_up(move_up), .move_down(move_down),
    .fg_colour(fg_colour), .bg_colour(bg_colour),
    .x(x), .y(y), .colour(colour), .plot(plot), .busy(busy), .done(done),
    .pos_x(pos_x), .pos_y(pos_y)
  );

  always #5 clk = ~clk;

  function automatic int clampi(int v, int hi);
    if (v < 0) return 0;
    if (v > hi) return hi;
    return v;
  endfunction

  // Scoreboard: expected pixels of one box sweep in raster order.
  task automatic push_box(input int x0, input int y0, input logic [2:0] c, input bit is_draw);
    for (int j = 0; j < BOX_H; j++)
      for (int i = 0; i < BOX_W; i++) begin
`ifdef SPRITE_OUTLINE_EN
        if (is_draw && !(i == 0 || i == BOX_W-1 || j == 0 || j == BOX_H-1)) continue;
`endif
        exp_q.push_back({XW'(x0 + i), YW'(y0 + j), c});
      end
  endtask

  // Collects plotted pixels from the current cycle (k=0) until done; returns
  // the cycle of done (-1 on timeout) and busy one cycle after done.
  task automatic collect(input bit hold, output int done_at, output logic busy_after);
    done_at = -1;
    busy_after = 1'b1;
    for (int k = 0; k <= MAXC; k++) begin
      if (k > 0) @(negedge clk);
      if (k == 1 && !hold) go = 1'b0;
      #1;
      if (plot) got_q.push_back({x, y, colour});
      if (done) begin
        done_at = k;
        break;
      end
    end
    if (done_at >= 0) begin
      @(negedge clk);
      #1;
      busy_after = busy;
    end
  endtask

  task automatic test_reset;
    int d; logic b;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    checks++; if (plot !== 1'b0) begin errors++; $display("FAIL reset_plot got=%b exp=0", plot); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", done); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL reset_busy got=%b exp=1", busy); end
    checks++; if (pos_x !== XW'(X_INIT) || pos_y !== YW'(Y_INIT)) begin
      errors++; $display("FAIL reset_pos got=(%0d,%0d) exp=(%0d,%0d)", pos_x, pos_y, X_INIT, Y_INIT); end
    push_box(X_INIT, Y_INIT, fg_colour, 1'b1);
    reset = 1'b0;
    collect(1'b0, d, b);
    checks++; if (d !== BOX_W*BOX_H) begin errors++; $display("FAIL init_done_cycle got=%0d exp=%0d", d, BOX_W*BOX_H); end
    checks++; if (b !== 1'b0) begin errors++; $display("FAIL init_busy_after got=%b exp=0", b); end
    checks++; if (got_q.size() != exp_q.size()) begin
      errors++; $display("FAIL init_pix_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      pix_t e, g;
      e = exp_q.pop_front(); g = got_q.pop_front();
      checks++; if (g !== e) begin errors++; $display("FAIL init_pixel got=%h exp=%h", g, e); end
    end
    exp_q.delete(); got_q.delete();
    px = X_INIT; py = Y_INIT;
  endtask

  // Table of moves {left,right,up,down} walking into the left and bottom
  // clamps and through cancelling combinations.
  task automatic test_moves;
    logic [3:0] tbl [11] = '{4'b0100, 4'b1000, 4'b1000, 4'b1000, 4'b1000,
                             4'b0001, 4'b0001, 4'b0001, 4'b1100, 4'b0010, 4'b0111};
    for (int t = 0; t < 11; t++) begin
      int nx, ny, d, lat; logic b; bit noop;
      nx = clampi(px + STEP*(int'(tbl[t][2]) - int'(tbl[t][3])), SCREEN_W - BOX_W);
      ny = clampi(py + STEP*(int'(tbl[t][0]) - int'(tbl[t][1])), SCREEN_H - BOX_H);
      noop = (nx == px) && (ny == py);
      lat = noop ? 2 : 2 + 2*BOX_W*BOX_H;
      if (!noop) begin
        push_box(px, py, bg_colour, 1'b0);
        push_box(nx, ny, fg_colour, 1'b1);
      end
      {move_left, move_right, move_up, move_down} = tbl[t];
      go = 1'b1;
      collect(1'b0, d, b);
      checks++; if (d !== lat) begin errors++; $display("FAIL move%0d_done_cycle got=%0d exp=%0d", t, d, lat); end
      checks++; if (b !== 1'b0) begin errors++; $display("FAIL move%0d_busy_after got=%b exp=0", t, b); end
      checks++; if (got_q.size() != exp_q.size()) begin
        errors++; $display("FAIL move%0d_pix_count got=%0d exp=%0d", t, got_q.size(), exp_q.size()); end
      while (exp_q.size() > 0 && got_q.size() > 0) begin
        pix_t e, g;
        e = exp_q.pop_front(); g = got_q.pop_front();
        checks++; if (g !== e) begin errors++; $display("FAIL move%0d_pixel got=%h exp=%h", t, g, e); end
      end
      exp_q.delete(); got_q.delete();
      checks++; if (pos_x !== XW'(nx) || pos_y !== YW'(ny)) begin
        errors++; $display("FAIL move%0d_pos got=(%0d,%0d) exp=(%0d,%0d)", t, pos_x, pos_y, nx, ny); end
      px = nx; py = ny;
    end
    {move_left, move_right, move_up, move_down} = 4'b0000;
  endtask

  // go held high: one move per IDLE visit, the second starting from IDLE.
  task automatic test_go_held;
    int d, nx, ny; logic b;
    {move_left, move_right, move_up, move_down} = 4'b0101;
    for (int m = 0; m < 2; m++) begin
      nx = clampi(px + STEP, SCREEN_W - BOX_W);
      ny = clampi(py + STEP, SCREEN_H - BOX_H);
      push_box(px, py, bg_colour, 1'b0);
      push_box(nx, ny, fg_colour, 1'b1);
      go = 1'b1;
      collect(m == 0, d, b);
      checks++; if (d !== 34) begin errors++; $display("FAIL held%0d_done_cycle got=%0d exp=34", m, d); end
      checks++; if (b !== 1'b0) begin errors++; $display("FAIL held%0d_busy_after got=%b exp=0", m, b); end
      checks++; if (got_q.size() != exp_q.size()) begin
        errors++; $display("FAIL held%0d_pix_count got=%0d exp=%0d", m, got_q.size(), exp_q.size()); end
      while (exp_q.size() > 0 && got_q.size() > 0) begin
        pix_t e, g;
        e = exp_q.pop_front(); g = got_q.pop_front();
        checks++; if (g !== e) begin errors++; $display("FAIL held%0d_pixel got=%h exp=%h", m, g, e); end
      end
      exp_q.delete(); got_q.delete();
      checks++; if (pos_x !== XW'(nx) || pos_y !== YW'(ny)) begin
        errors++; $display("FAIL held%0d_pos got=(%0d,%0d) exp=(%0d,%0d)", m, pos_x, pos_y, nx, ny); end
      px = nx; py = ny;
    end
    repeat (3) @(negedge clk);
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL held_no_extra_move busy=%b exp=0", busy); end
    {move_left, move_right, move_up, move_down} = 4'b0000;
  endtask

  // Reset landing on erase pixel 7 (cx=3, cy=1) abandons the move.
  task automatic test_reset_mid_erase;
    int d; logic b;
    move_right = 1'b1;
    go = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      if (k == 1) go = 1'b0;
    end
    #1;
    checks++; if (plot !== 1'b1 || {x, y, colour} !== {XW'(px + 3), YW'(py + 1), bg_colour}) begin
      errors++; $display("FAIL erase_px7 got=%b/%h exp=1/%h", plot, {x, y, colour}, {XW'(px + 3), YW'(py + 1), bg_colour}); end
    reset = 1'b1;
    move_right = 1'b0;
    @(negedge clk);
    #1;
    checks++; if (plot !== 1'b0) begin errors++; $display("FAIL midreset_plot got=%b exp=0", plot); end
    checks++; if (busy !== 1'b1 || done !== 1'b0) begin
      errors++; $display("FAIL midreset_busy_done got=%b%b exp=10", busy, done); end
    checks++; if (pos_x !== XW'(X_INIT) || pos_y !== YW'(Y_INIT)) begin
      errors++; $display("FAIL midreset_pos got=(%0d,%0d) exp=(%0d,%0d)", pos_x, pos_y, X_INIT, Y_INIT); end
    push_box(X_INIT, Y_INIT, fg_colour, 1'b1);
    reset = 1'b0;
    collect(1'b0, d, b);
    checks++; if (d !== BOX_W*BOX_H) begin errors++; $display("FAIL redraw_done_cycle got=%0d exp=%0d", d, BOX_W*BOX_H); end
    checks++; if (got_q.size() != exp_q.size()) begin
      errors++; $display("FAIL redraw_pix_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      pix_t e, g;
      e = exp_q.pop_front(); g = got_q.pop_front();
      checks++; if (g !== e) begin errors++; $display("FAIL redraw_pixel got=%h exp=%h", g, e); end
    end
    exp_q.delete(); got_q.delete();
    px = X_INIT; py = Y_INIT;
  endtask

  initial begin
    test_reset;
    test_moves;
    test_go_held;
    test_reset_mid_erase;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sprite_mover.md
Name: sprite_mover

Overview:
- Parametrised successor to the fixed 4x4 player drawer: plots a BOX_W x BOX_H rectangle into the 160x120 VGA adapter's pixel-write port.
- On a move request it erases the box at its old position in background colour, computes a clamped new position and redraws the box in foreground colour.
- Sits between the game-control logic (direction buttons, go strobe) and the single vga_adapter instance; drives x, y, colour and plot directly.

Parameters:
- BOX_W, 4, box width in pixels (1..16)
- BOX_H, 4, box height in pixels (1..16)
- SCREEN_W, 160, screen width in pixels
- SCREEN_H, 120, screen height in pixels
- STEP, 1, pixels moved per request on each axis
- X_INIT, 2, x of the box's top-left corner after reset
- Y_INIT, 114, y of the box's top-left corner after reset
- XW, 8, x coordinate width
- YW, 7, y coordinate width

Ports:
- clk  in  1  system clock (CLOCK_50 domain)
- reset  in  1  synchronous, active-high reset
- go  in  1  move request; sampled only in IDLE
- move_left, move_right, move_up, move_down  in  1 each  direction, sampled with go
- fg_colour  in  3  box colour
- bg_colour  in  3  erase colour
- x  out  XW  pixel x to the adapter
- y  out  YW  pixel y to the adapter
- colour  out  3  pixel colour to the adapter
- plot  out  1  pixel write enable
- busy  out  1  high whenever the state is not IDLE
- done  out  1  one-cycle pulse when a request (or the post-reset draw) completes
- pos_x  out  XW  current top-left x
- pos_y  out  YW  current top-left y

Behaviour:
- Reset (synchronous, active-high), applied at any time, including mid-erase or mid-draw:
  - state = DRAW; pos_x = X_INIT; pos_y = Y_INIT; counters = 0; direction latch = 0.
  - While reset is held, plot = 0, done = 0, busy = 1.
  - On the first cycle after reset deasserts, the initial box is drawn.
  - A partially erased box is not cleaned up.
- States:
  - IDLE: go=1 latches the four direction bits and moves to CALC. busy=0.
  - CALC (1 cycle): computes target tx, ty.
    - If tx==pos_x and ty==pos_y, go to DONE.
    - Otherwise go to ERASE.
  - ERASE (BOX_W*BOX_H cycles): plot=1, colour=bg_colour, at the old position. On the last pixel, pos <= target and the state moves to DRAW.
  - DRAW (BOX_W*BOX_H cycles): plot=1, colour=fg_colour, at pos. After the last pixel, go to DONE.
  - DONE (1 cycle): done=1, plot=0, then IDLE.
- Pixel sweep:
  - Counters cx in 0..BOX_W-1 and cy in 0..BOX_H-1, in raster order with cx fastest; both clear on entry to ERASE and DRAW.
  - x = pos_x+cx and y = pos_y+cy, presented in the same cycle as plot.
  - Outputs are Moore-decoded from registered state and counters.
- Target arithmetic:
  - dx = STEP*(move_right - move_left) and dy = STEP*(move_down - move_up); opposing bits cancel to 0.
  - Sums are computed signed at XW+1 / YW+1 bits.
  - Results are clamped to [0, SCREEN_W-BOX_W] and [0, SCREEN_H-BOX_H]. No wrap-around.
- go while busy is ignored, not queued.
- plot is 0 in IDLE, CALC and DONE; x, y and colour are don't-care when plot=0.
- Latency (4x4 box), counting from the cycle in which go is sampled:
  - Moving request: CALC at +1, ERASE at +2..+17, DRAW at +18..+33, done at +34, IDLE at +35.
  - Clamped no-op: done at +2.

Optional Feature:
- Macro SPRITE_OUTLINE_EN.
- When defined: in DRAW, plot=1 only when cx==0, cx==BOX_W-1, cy==0 or cy==BOX_H-1. The counters still sweep the full box, so timing is unchanged. ERASE always fills the full box.
- When undefined: DRAW plots a solid box.

Test Plan:
- Reset then release, defaults -> 16 plot pulses in fg_colour covering x 2..5, y 114..117 in raster order; done one cycle later; pos=(2,114); busy drops the next cycle.
- From (2,114), go with move_right=1 -> 16 bg_colour pixels at x 2..5, then 16 fg_colour pixels at x 3..6; done at go+34; pos_x=3.
- At pos_x=0, go with move_left=1 -> no plot pulses; done at go+2; pos unchanged.
- At pos_y=116 with BOX_H=4, go with move_down=1, STEP=4 -> target clamped to y=116; no-op path.
- move_left and move_right both 1 -> no-op path.
- go held high throughout a move -> exactly one move per IDLE visit.
- Reset asserted at ERASE pixel 7 -> plot=0 next cycle; initial box redrawn at (X_INIT, Y_INIT).
- With SPRITE_OUTLINE_EN, 4x4 box -> 12 plot pulses in DRAW, none at (1,1),(2,1),(1,2),(2,2) offsets; done timing identical to solid mode.
